// File: rtl/point_table_arbiter_if.sv
// rtl/point_table_arbiter_if.sv - point table access bus: one writer, two readers, ready flag
interface point_table_arbiter_if #(
  parameter int AW = 6,
  parameter int CW = 8
);
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_x;
  logic [CW-1:0] wr_y;
  logic          wr_gnt;

  logic          ra_req;
  logic [AW-1:0] ra_addr;
  logic          ra_gnt;
  logic          ra_valid;
  logic [CW-1:0] ra_x;
  logic [CW-1:0] ra_y;

  logic          rb_req;
  logic [AW-1:0] rb_addr;
  logic          rb_gnt;
  logic          rb_valid;
  logic [CW-1:0] rb_x;
  logic [CW-1:0] rb_y;

  logic          table_ready;

  modport master (
    output wr_req, wr_addr, wr_x, wr_y,
    output ra_req, ra_addr, rb_req, rb_addr,
    input  wr_gnt, ra_gnt, rb_gnt,
    input  ra_valid, ra_x, ra_y, rb_valid, rb_x, rb_y,
    input  table_ready
  );

  modport slave (
    input  wr_req, wr_addr, wr_x, wr_y,
    input  ra_req, ra_addr, rb_req, rb_addr,
    output wr_gnt, ra_gnt, rb_gnt,
    output ra_valid, ra_x, ra_y, rb_valid, rb_x, rb_y,
    output table_ready
  );
endinterface

// File: rtl/point_table_arbiter.sv
// rtl/point_table_arbiter.sv - point table with writer-priority, round-robin read arbitration
// One access per clock; reads are held off until a full 0..N_PTS-1 write pass has completed.
module point_table_arbiter #(
  parameter int N_PTS = 64,
  parameter int AW    = 6,
  parameter int CW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  point_table_arbiter_if.slave  bus
);

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N_PTS - 1);

  logic [CW-1:0] pt_x [N_PTS];
  logic [CW-1:0] pt_y [N_PTS];

  logic          wr_gnt;
  logic          ra_gnt;
  logic          rb_gnt;
  logic          last_read;
  logic          table_ready;

  logic          ra_valid;
  logic [CW-1:0] ra_x;
  logic [CW-1:0] ra_y;
  logic          rb_valid;
  logic [CW-1:0] rb_x;
  logic [CW-1:0] rb_y;

  // Grants are purely combinational so a requester sees acceptance in the same cycle.
  always_comb begin
    wr_gnt = 1'b0;
    ra_gnt = 1'b0;
    rb_gnt = 1'b0;
    if (!rst) begin
      if (bus.wr_req) begin
        wr_gnt = 1'b1;
      end else if (table_ready) begin
        if (bus.ra_req && bus.rb_req) begin
          if (last_read == PORT_B) ra_gnt = 1'b1;
          else                     rb_gnt = 1'b1;
        end else begin
          ra_gnt = bus.ra_req;
          rb_gnt = bus.rb_req;
        end
      end
    end
  end

  // Table contents are deliberately not reset; table_ready guards their use.
  always_ff @(posedge clk) begin
    if (wr_gnt) begin
      pt_x[bus.wr_addr] <= bus.wr_x;
      pt_y[bus.wr_addr] <= bus.wr_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      table_ready <= 1'b0;
      last_read   <= PORT_B;
    end else begin
      if (wr_gnt && bus.wr_addr == '0)
        table_ready <= 1'b0;
      else if (wr_gnt && bus.wr_addr == LAST_ADDR)
        table_ready <= 1'b1;

      if (ra_gnt)
        last_read <= PORT_A;
      else if (rb_gnt)
        last_read <= PORT_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra_valid <= 1'b0;
      ra_x     <= '0;
      ra_y     <= '0;
      rb_valid <= 1'b0;
      rb_x     <= '0;
      rb_y     <= '0;
    end else begin
      ra_valid <= ra_gnt;
      rb_valid <= rb_gnt;
      if (ra_gnt) begin
        ra_x <= pt_x[bus.ra_addr];
        ra_y <= pt_y[bus.ra_addr];
      end
      if (rb_gnt) begin
        rb_x <= pt_x[bus.rb_addr];
        rb_y <= pt_y[bus.rb_addr];
      end
    end
  end

  assign bus.wr_gnt      = wr_gnt;
  assign bus.ra_gnt      = ra_gnt;
  assign bus.rb_gnt      = rb_gnt;
  assign bus.ra_valid    = ra_valid;
  assign bus.ra_x        = ra_x;
  assign bus.ra_y        = ra_y;
  assign bus.rb_valid    = rb_valid;
  assign bus.rb_x        = rb_x;
  assign bus.rb_y        = rb_y;
  assign bus.table_ready = table_ready;

endmodule

// File: tb/tb_point_table_arbiter.sv
// tb/tb_point_table_arbiter.sv - scoreboard bench for point_table_arbiter
module tb_point_table_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  point_table_arbiter_if #(.AW(6), .CW(8)) bus ();

  point_table_arbiter #(.N_PTS(64), .AW(6), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] q_a [$];
  logic [15:0] q_b [$];
  logic [7:0]  m_x [64];
  logic [7:0]  m_y [64];
  bit          m_last  = 1'b1;
  bit          m_ready = 1'b0;
  logic [15:0] exp_a;
  logic [15:0] exp_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected read data whenever a port presents valid.
  always @(negedge clk) begin
    check("gnt_onehot0", 32'($countones({bus.wr_gnt, bus.ra_gnt, bus.rb_gnt}) <= 1), 1);
    if (bus.ra_valid) begin
      if (q_a.size() == 0) begin
        check("ra_spurious_valid", 1, 0);
      end else begin
        exp_a = q_a.pop_front();
        check("ra_data", {bus.ra_x, bus.ra_y}, exp_a);
      end
    end
    if (bus.rb_valid) begin
      if (q_b.size() == 0) begin
        check("rb_spurious_valid", 1, 0);
      end else begin
        exp_b = q_b.pop_front();
        check("rb_data", {bus.rb_x, bus.rb_y}, exp_b);
      end
    end
  end

  task automatic rd_cycle(input bit a, input bit b, input int aa, input int ab);
    bit ea = 1'b0;
    bit eb = 1'b0;
    bus.wr_req  = 1'b0;
    bus.ra_req  = a;
    bus.ra_addr = 6'(aa);
    bus.rb_req  = b;
    bus.rb_addr = 6'(ab);
    if (m_ready) begin
      if (a && b) begin
        if (m_last) ea = 1'b1;
        else        eb = 1'b1;
      end else begin
        ea = a;
        eb = b;
      end
    end
    if (ea) begin
      q_a.push_back({m_x[aa], m_y[aa]});
      m_last = 1'b0;
    end
    if (eb) begin
      q_b.push_back({m_x[ab], m_y[ab]});
      m_last = 1'b1;
    end
    @(negedge clk);
    check("rd_ra_gnt", bus.ra_gnt, ea);
    check("rd_rb_gnt", bus.rb_gnt, eb);
    check("rd_wr_gnt", bus.wr_gnt, 0);
    check("rd_table_ready", bus.table_ready, m_ready);
    tick();
  endtask

  task automatic wr_cycle(input int addr, input int x, input int y, input bit rd);
    bus.wr_req  = 1'b1;
    bus.wr_addr = 6'(addr);
    bus.wr_x    = 8'(x);
    bus.wr_y    = 8'(y);
    bus.ra_req  = rd;
    bus.rb_req  = rd;
    @(negedge clk);
    check("wr_gnt", bus.wr_gnt, 1);
    check("wr_ra_gnt", bus.ra_gnt, 0);
    check("wr_rb_gnt", bus.rb_gnt, 0);
    check("wr_table_ready", bus.table_ready, m_ready);
    m_x[addr] = 8'(x);
    m_y[addr] = 8'(y);
    if (addr == 0)  m_ready = 1'b0;
    if (addr == 63) m_ready = 1'b1;
    tick();
  endtask

  task automatic idle_cycle();
    bus.wr_req = 1'b0;
    bus.ra_req = 1'b0;
    bus.rb_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.wr_req  = 1'b1;
    bus.wr_addr = '0;
    bus.wr_x    = '0;
    bus.wr_y    = '0;
    bus.ra_req  = 1'b1;
    bus.ra_addr = '0;
    bus.rb_req  = 1'b1;
    bus.rb_addr = '0;

    // Reset held with every requester active
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      check("rst_gnts", {bus.wr_gnt, bus.ra_gnt, bus.rb_gnt}, 0);
      check("rst_valids", {bus.ra_valid, bus.rb_valid}, 0);
      check("rst_data", {bus.ra_x, bus.ra_y, bus.rb_x, bus.rb_y}, 0);
      check("rst_table_ready", bus.table_ready, 0);
    end
    tick();
    rst = 1'b0;

    // Reads held off before the table is generated
    rd_cycle(1, 1, 5, 6);
    rd_cycle(1, 0, 5, 0);

    for (int i = 0; i < 64; i++) wr_cycle(i, i, 255 - i, 1'b0);
    idle_cycle();
    check("fill_table_ready", bus.table_ready, 1);
    tick();

    // Fairness: expect A,B,A,B,A,B
    for (int k = 0; k < 6; k++) rd_cycle(1, 1, k, 63 - k);
    idle_cycle();
    tick();

    // Latency: read addr 10 on port A
    rd_cycle(1, 0, 10, 0);
    idle_cycle();
    check("lat_ra_valid", bus.ra_valid, 1);
    check("lat_rb_valid", bus.rb_valid, 0);
    tick();
    idle_cycle();
    check("lat_ra_valid_pulse", bus.ra_valid, 0);
    check("lat_ra_hold", {bus.ra_x, bus.ra_y}, {8'd10, 8'd245});
    tick();

    // Writer priority over two requesting readers, ready clears
    wr_cycle(0, 8'h77, 8'h88, 1'b1);
    rd_cycle(1, 1, 3, 4);
    for (int i = 1; i < 64; i++) wr_cycle(i, i, 255 - i, 1'b1);
    rd_cycle(1, 0, 0, 0);
    idle_cycle();
    tick();

    // Reset in the cycle after a grant
    rd_cycle(1, 0, 20, 0);
    bus.ra_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_gnts", {bus.wr_gnt, bus.ra_gnt, bus.rb_gnt}, 0);
    tick();
    rst = 1'b0;
    m_ready = 1'b0;
    m_last  = 1'b1;
    @(negedge clk);
    check("mid_rst_ra_valid", bus.ra_valid, 0);
    check("mid_rst_ra_data", {bus.ra_x, bus.ra_y}, 0);
    check("mid_rst_table_ready", bus.table_ready, 0);
    tick();
    rd_cycle(1, 1, 20, 21);
    rd_cycle(0, 1, 0, 21);

    idle_cycle();
    tick();
    idle_cycle();
    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
